sub_bytes_engine: RTL and testbench
===================================

# sub_bytes_engine

Iterative, parametrised AES byte-substitution unit that applies either the forward S-box (SubBytes) or the inverse S-box (InvSubBytes) to a 128-bit state. The mode is selected per transaction. It processes `BYTES_PER_CYCLE` bytes per clock and uses valid/ready handshakes on both sides. It sits between the round-key XOR and ShiftRows/InvShiftRows stages of the shared encrypt/decrypt datapath.

## Interface
Parameters:
- `BYTES_PER_CYCLE`, default 4: bytes substituted per clock. Legal values are 1, 2, 4, 8 and 16. Any other value is an elaboration error.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input transaction offered.
- `in_ready`  out  1  engine can accept an input this cycle.
- `in_inverse`  in  1  mode: 0 = forward S-box, 1 = inverse S-box. Sampled with `in_data`.
- `in_data`  in  128  state. Byte k (k = 0..15) is `in_data[8*(15-k) +: 8]`, so byte 0 is in bits [127:120].
- `out_valid`  out  1  `out_data` holds a completed result.
- `out_ready`  in  1  downstream accepts the result.
- `out_inverse`  out  1  mode of the transaction currently in `out_data`.
- `out_data`  out  128  substituted state, same byte ordering as `in_data`.
- `busy`  out  1  high in RUN or DONE.

## Operation
- N = 16 / `BYTES_PER_CYCLE` substitution cycles per transaction.
- Byte map must equal the FIPS-197 S-box / inverse S-box bit-exactly. Implementation is free: lookup tables or GF(2^8) inverse plus affine logic.
- Internal state: 128-bit working register, mode bit, chunk counter of clog2(N) bits (minimum 1 bit), FSM.
- FSM states:
  - **IDLE**
    - `in_ready` = 1.
    - On `in_valid`: load the working register and mode, set counter = 0, go to RUN.
  - **RUN**
    - Each cycle, replace bytes `counter*BYTES_PER_CYCLE` through `counter*BYTES_PER_CYCLE + BYTES_PER_CYCLE - 1` of the working register with their mapped values.
    - Increment the counter.
    - On the cycle where counter = N-1, go to DONE.
  - **DONE**
    - `out_valid` = 1. `out_data` and `out_inverse` are held stable while `out_ready` = 0.
    - On `out_ready`:
      - if `in_valid` is also 1, accept the new input in the same cycle and go directly to RUN;
      - otherwise go to IDLE.
- `in_ready` = (state == IDLE) || (state == DONE && `out_ready`). This is a combinational path from `out_ready`.
- `in_ready` = 0 throughout RUN. Inputs are not sampled in RUN.
- Each substitution step uses only the stored mode, never the live `in_inverse`.
- Changes on `in_data` or `in_inverse` without a handshake have no effect.

## Timing
- Reset values:
  - state = IDLE, counter = 0;
  - `out_valid` = 0, `out_data` = 0, `out_inverse` = 0, `busy` = 0;
  - `in_ready` = 1 in the first cycle after reset deassertion.
- Latency: input accepted at edge E0, `out_valid` high after edge E0+N.
  - `BYTES_PER_CYCLE` = 16: one cycle.
  - `BYTES_PER_CYCLE` = 4: four cycles.
  - `BYTES_PER_CYCLE` = 1: sixteen cycles.
- Throughput with `out_ready` held at 1: one result per N+1 cycles. The DONE cycle overlaps the next accept.
- `rst` asserted in any state, including mid-RUN or DONE with a stalled output:
  - the transaction is aborted and all state returns to reset values at that edge;
  - no partial result is ever presented.
- `rst` has priority over any handshake in the same cycle.
- Bytes not yet processed remain unmodified in the working register. They are not visible outside the block.

## Test plan
- **Forward, default parameter.** `in_data`=000102030405060708090A0B0C0D0E0F, `in_inverse`=0 → `out_data`=637C777BF26B6FC53001672BFED7AB76, `out_inverse`=0, `out_valid` rises 4 cycles after accept.
- **Inverse round-trip.** Feed 637C777BF26B6FC53001672BFED7AB76 with `in_inverse`=1 → 000102030405060708090A0B0C0D0E0F. Separately, all-zero input with `in_inverse`=1 → 52 repeated 16 times.
- **Parameter sweep.** `BYTES_PER_CYCLE` ∈ {1, 2, 8, 16} with the forward vector above → identical result at latency 16, 8, 2 and 1 respectively. Exhaustive 0x00–0xFF sweep, 16 states per mode, checked against a golden model (e.g. S(53)=ED, InvS(ED)=53).
- **Back-pressure.** Hold `out_ready`=0 for 10 cycles in DONE → `out_data` stable, `in_ready`=0. Raise `out_ready` with `in_valid`=1 and a new inverse-mode input → accepted in the same cycle, next result correct and marked `out_inverse`=1.
- **Mode isolation.** Toggle `in_inverse` and `in_data` every cycle during RUN → result depends only on the values at the accept edge.
- **Reset mid-operation.** Assert `rst` on the second RUN cycle → next cycle `out_valid`=0, `out_data`=0, `busy`=0, `in_ready`=1. A following transaction completes correctly.

Source files
------------

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes / InvSubBytes unit: BYTES_PER_CYCLE bytes per clock,
// valid/ready on both sides, per-transaction mode select.
module sub_bytes_engine #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inverse,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_inverse,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int N       = 16 / BYTES_PER_CYCLE;
    localparam int CW      = (N > 1) ? $clog2(N) : 1;
    localparam int CHUNK_W = 8 * BYTES_PER_CYCLE;

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
            $error("sub_bytes_engine: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [127:0]        work;
    logic [127:0]        work_nxt;
    logic                mode;
    logic [CW-1:0]       cnt;
    logic                load;
    logic                last;
    logic [CHUNK_W-1:0]  chunk_sub;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); zero maps to zero
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int unsigned i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] y);
        return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        return inv ? gf_inv(inv_affine(b)) : fwd_affine(gf_inv(b));
    endfunction

    assign last = (cnt == CW'(N - 1));

    // The working register rotates by one chunk per RUN cycle so the chunk being
    // substituted is always the top one; after N cycles byte order is restored.
    always_comb begin
        chunk_sub = '0;
        for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
            chunk_sub[CHUNK_W - 1 - 8*j -: 8] = sub_byte(work[127 - 8*j -: 8], mode);
        end
        work_nxt = (work << CHUNK_W) | 128'(chunk_sub);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work <= '0;
            mode <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            work <= in_data;
            mode <= in_inverse;
            cnt  <= '0;
        end else if (state == RUN) begin
            work <= work_nxt;
            cnt  <= last ? '0 : cnt + 1'b1;
        end
    end

    // Gated so a partially substituted state never reaches the output
    assign out_data    = (state == DONE) ? work : '0;
    assign out_inverse = (state == DONE) ? mode : 1'b0;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench: one engine per legal BYTES_PER_CYCLE, checked every cycle
// against a table-driven transaction model plus literal FIPS-197 vectors.
module tb_sub_bytes_engine;

    localparam int NI = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid    [NI];
    logic         in_ready    [NI];
    logic         in_inverse  [NI];
    logic [127:0] in_data     [NI];
    logic         out_valid   [NI];
    logic         out_ready   [NI];
    logic         out_inverse [NI];
    logic [127:0] out_data    [NI];
    logic         busy        [NI];

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            sub_bytes_engine #(.BYTES_PER_CYCLE(1 << g)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (in_valid[g]),
                .in_ready   (in_ready[g]),
                .in_inverse (in_inverse[g]),
                .in_data    (in_data[g]),
                .out_valid  (out_valid[g]),
                .out_ready  (out_ready[g]),
                .out_inverse(out_inverse[g]),
                .out_data   (out_data[g]),
                .busy       (busy[g])
            );
        end
    endgenerate

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];

    bit           m_pending [NI];
    int           m_left    [NI];
    logic [127:0] m_res     [NI];
    logic         m_inv     [NI];
    bit           m_acc     [NI];

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] V_PLAIN = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V_SUB   = 128'h637c777bf26b6fc53001672bfed7ab76;

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = d[8*(15-k) +: 8];
            r[8*(15-k) +: 8] = inv ? isb[b] : sb[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] sweep_vec(input int s);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[8*(15-k) +: 8] = 8'(16*s + k);
        return v;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Compare all engines against the model, advance the model, then clock.
    task automatic step();
        #1;
        for (int i = 0; i < NI; i++) begin
            logic ev;
            logic eir;
            ev  = m_pending[i] && (m_left[i] == 0);
            eir = !m_pending[i] || (ev && out_ready[i]);
            chk($sformatf("u%0d in_ready", i),  128'(in_ready[i]),  128'(eir));
            chk($sformatf("u%0d out_valid", i), 128'(out_valid[i]), 128'(ev));
            chk($sformatf("u%0d busy", i),      128'(busy[i]),      128'(m_pending[i]));
            if (ev) begin
                chk($sformatf("u%0d out_data", i),    out_data[i],          m_res[i]);
                chk($sformatf("u%0d out_inverse", i), 128'(out_inverse[i]), 128'(m_inv[i]));
            end
            m_acc[i] = 1'b0;
            if (rst) begin
                m_pending[i] = 1'b0;
                m_left[i]    = 0;
            end else begin
                if (ev && out_ready[i]) m_pending[i] = 1'b0;
                if (in_valid[i] && eir) begin
                    m_acc[i]     = 1'b1;
                    m_pending[i] = 1'b1;
                    m_left[i]    = 16 >> i;
                    m_res[i]     = ref_sub(in_data[i], in_inverse[i]);
                    m_inv[i]     = in_inverse[i];
                end else if (m_pending[i] && m_left[i] > 0) begin
                    m_left[i]--;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic bit any_pending();
        bit r = 1'b0;
        for (int i = 0; i < NI; i++) r |= m_pending[i];
        return r;
    endfunction

    function automatic bit all_valid();
        bit r = 1'b1;
        for (int i = 0; i < NI; i++) r &= (out_valid[i] === 1'b1);
        return r;
    endfunction

    task automatic drain();
        int c = 0;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        while (any_pending() && c < 60) begin
            step();
            c++;
        end
        chk("drain timeout", 128'(any_pending()), 128'(0));
    endtask

    task automatic wait_all_valid();
        int c = 0;
        while (!all_valid() && c < 40) begin
            step();
            c++;
        end
    endtask

    initial begin
        logic [2047:0] tbl;
        int            lat [NI];
        int            idx [NI];
        int            c;
        bit            more;

        tbl = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
               128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
               128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
               128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
               128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
               128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
               128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
               128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) sb[i] = tbl[2047 - 8*i -: 8];
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);

        for (int i = 0; i < NI; i++) begin
            in_valid[i]   = 1'b0;
            in_inverse[i] = 1'b0;
            in_data[i]    = '0;
            out_ready[i]  = 1'b0;
            m_pending[i]  = 1'b0;
            m_left[i]     = 0;
            m_res[i]      = '0;
            m_inv[i]      = 1'b0;
            m_acc[i]      = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("model S(53)",      128'(sb[8'h53]),  128'(8'hed));
        chk("model InvS(ED)",   128'(isb[8'hed]), 128'(8'h53));
        chk("model fwd vector", ref_sub(V_PLAIN, 1'b0), V_SUB);
        chk("model inv zero",   ref_sub('0, 1'b1), {16{8'h52}});

        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d reset out_data", i),    out_data[i],          '0);
            chk($sformatf("u%0d reset out_inverse", i), 128'(out_inverse[i]), 128'(0));
            chk($sformatf("u%0d reset in_ready", i),    128'(in_ready[i]),    128'(1));
        end

        // forward vector, latency, then stall in DONE while inputs churn
        for (int i = 0; i < NI; i++) begin
            in_valid[i]   = 1'b1;
            in_data[i]    = V_PLAIN;
            in_inverse[i] = 1'b0;
            lat[i]        = -1;
        end
        step();
        for (c = 1; c <= 20; c++) begin
            for (int i = 0; i < NI; i++) begin
                in_valid[i]   = 1'b1;
                in_data[i]    = rnd128();
                in_inverse[i] = 1'($urandom_range(1));
            end
            step();
            for (int i = 0; i < NI; i++)
                if (lat[i] < 0 && out_valid[i] === 1'b1) lat[i] = c;
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d latency", i),     128'(lat[i]),         128'(16 >> i));
            chk($sformatf("u%0d fwd result", i),  out_data[i],          V_SUB);
            chk($sformatf("u%0d fwd mode", i),    128'(out_inverse[i]), 128'(0));
        end

        // release with a same-cycle inverse-mode accept
        for (int i = 0; i < NI; i++) begin
            out_ready[i]  = 1'b1;
            in_valid[i]   = 1'b1;
            in_data[i]    = V_SUB;
            in_inverse[i] = 1'b1;
        end
        step();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d accepted busy", i), 128'(busy[i]),      128'(1));
            chk($sformatf("u%0d accepted valid", i), 128'(out_valid[i]), 128'(0));
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
        end
        wait_all_valid();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d inv valid", i),  128'(out_valid[i]),   128'(1));
            chk($sformatf("u%0d inv result", i), out_data[i],          V_PLAIN);
            chk($sformatf("u%0d inv mode", i),   128'(out_inverse[i]), 128'(1));
            out_ready[i]  = 1'b1;
            in_valid[i]   = 1'b1;
            in_data[i]    = '0;
            in_inverse[i] = 1'b1;
        end
        step();
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
        end
        wait_all_valid();
        for (int i = 0; i < NI; i++)
            chk($sformatf("u%0d inv zero", i), out_data[i], {16{8'h52}});

        // reset on the second RUN cycle
        for (int i = 0; i < NI; i++) begin
            out_ready[i]  = 1'b1;
            in_valid[i]   = 1'b1;
            in_data[i]    = rnd128();
            in_inverse[i] = 1'b0;
        end
        step();
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d rst out_valid", i), 128'(out_valid[i]), 128'(0));
            chk($sformatf("u%0d rst out_data", i),  out_data[i],        '0);
            chk($sformatf("u%0d rst busy", i),      128'(busy[i]),      128'(0));
            chk($sformatf("u%0d rst in_ready", i),  128'(in_ready[i]),  128'(1));
        end

        // every byte value through both maps, back to back
        for (int i = 0; i < NI; i++) idx[i] = 0;
        c    = 0;
        more = 1'b1;
        while (more && c < 700) begin
            for (int i = 0; i < NI; i++) begin
                out_ready[i] = 1'b1;
                in_valid[i]  = (idx[i] < 32);
                if (idx[i] < 32) begin
                    in_data[i]    = sweep_vec(idx[i] % 16);
                    in_inverse[i] = (idx[i] >= 16);
                end
            end
            step();
            more = 1'b0;
            for (int i = 0; i < NI; i++) begin
                if (m_acc[i]) idx[i]++;
                if (idx[i] < 32) more = 1'b1;
            end
            c++;
        end
        chk("sweep timeout", 128'(more), 128'(0));
        drain();

        // random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(99) == 0);
            for (int i = 0; i < NI; i++) begin
                in_valid[i]   = 1'($urandom_range(1));
                in_data[i]    = rnd128();
                in_inverse[i] = 1'($urandom_range(1));
                out_ready[i]  = ($urandom_range(3) != 0);
            end
            step();
        end
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
